// File: rtl/nonint_pkg.sv
// nonint_pkg: shared types for the noninterference violation monitor.
//   state_t   - 2-bit state/status encoding (IDLE=0, RUN=1, PASS=2, FAIL=3)
//   PI_W_DEF  - default width of the miter primary-input vector
package nonint_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam int PI_W_DEF = 5;

endpackage

// File: rtl/nonint_trace_buf.sv
// nonint_trace_buf: ring buffer of the last DEPTH miter input vectors.
//   clock, reset  - rising-edge clock, async active-high reset
//   clr           - synchronous clear of all entries and the write pointer
//   wr_en/wr_data - append one entry at the write pointer (wraps mod DEPTH)
//   rd_idx        - 0 = most recent entry, 1 = the one before, ...
//   rd_data       - combinational read of the selected entry
module nonint_trace_buf
  import nonint_pkg::*;
#(
  parameter int PI_W  = PI_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [PI_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [PI_W-1:0]          rd_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0][PI_W-1:0] mem;
  logic [IDX_W-1:0]           wr_ptr;
  logic [IDX_W-1:0]           rd_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
    end else if (clr) begin
      mem    <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + 1'b1;  // DEPTH is a power of two, so this wraps
    end
  end

  // wr_ptr points at the next free slot; latest entry sits one behind it.
  // Unwritten slots hold the cleared value, so they read back as 0.
  assign rd_ptr  = wr_ptr - IDX_W'(1) - rd_idx;
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/nonint_violation_monitor.sv
// nonint_violation_monitor: bounded check on the noninterference miter's
// violation output. Counts steps after start, stops at the first violation
// (FAIL) or after BOUND clean steps (PASS), and keeps a trace of the last
// TRACE_DEPTH input vectors for counterexample readout.
//   clock, reset        - rising-edge clock, async active-high reset
//   start               - begin a check (IDLE only)
//   step_en             - miter advanced; pi_vec/po_viol valid
//   pi_vec, po_viol     - miter input vector and violation output
//   busy                - high in RUN
//   report_valid/ready  - result handshake (PASS or FAIL)
//   status              - state encoding
//   fail_cycle          - 0-based violating step index (0 unless FAIL)
//   steps_done          - steps counted in current/last run (saturating)
//   trace_rd_idx/data   - trace read, 0 = most recent step
module nonint_violation_monitor
  import nonint_pkg::*;
#(
  parameter int PI_W        = PI_W_DEF,
  parameter int CNT_W       = 16,
  parameter int BOUND       = 1000,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           step_en,
  input  logic [PI_W-1:0]                pi_vec,
  input  logic                           po_viol,
  output logic                           busy,
  output logic                           report_valid,
  input  logic                           report_ready,
  output logic [1:0]                     status,
  output logic [CNT_W-1:0]               fail_cycle,
  output logic [CNT_W-1:0]               steps_done,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [PI_W-1:0]                trace_rd_data
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BOUND - 1);

  state_t state;
  logic   trace_clr;
  logic   trace_wr;

  assign trace_clr = (state == ST_IDLE) && start;
  assign trace_wr  = (state == ST_RUN) && step_en;
  assign status    = state;

  // Single FSM; busy/report_valid are registered alongside the state so no
  // input reaches an output combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      report_valid <= 1'b0;
      fail_cycle   <= '0;
      steps_done   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RUN;
            busy       <= 1'b1;
            fail_cycle <= '0;
            steps_done <= '0;
          end
        end
        ST_RUN: begin
          if (step_en) begin
            if (steps_done != '1) steps_done <= steps_done + 1'b1;
            // Violation wins even on the last bounded step.
            if (po_viol) begin
              state        <= ST_FAIL;
              fail_cycle   <= steps_done;
              busy         <= 1'b0;
              report_valid <= 1'b1;
            end else if (steps_done == LAST_STEP) begin
              state        <= ST_PASS;
              busy         <= 1'b0;
              report_valid <= 1'b1;
            end
          end
        end
        ST_PASS, ST_FAIL: begin
          // Results and trace stay put until the next start.
          if (report_ready) begin
            state        <= ST_IDLE;
            report_valid <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          report_valid <= 1'b0;
        end
      endcase
    end
  end

  nonint_trace_buf #(
    .PI_W  (PI_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clock   (clock),
    .reset   (reset),
    .clr     (trace_clr),
    .wr_en   (trace_wr),
    .wr_data (pi_vec),
    .rd_idx  (trace_rd_idx),
    .rd_data (trace_rd_data)
  );

endmodule

// File: tb/tb_nonint_violation_monitor.sv
// Directed bench: two monitors (BOUND=4 and BOUND=1000) share one stimulus
// stream; each scenario checks whichever instance it is aimed at.
module tb_nonint_violation_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        step_en = 1'b0;
  logic [4:0]  pi_vec = '0;
  logic        po_viol = 1'b0;
  logic        report_ready = 1'b0;
  logic [2:0]  trace_rd_idx = '0;

  logic        busy4, rv4, busy1k, rv1k;
  logic [1:0]  st4, st1k;
  logic [15:0] fc4, fc1k, sd4, sd1k;
  logic [4:0]  td4, td1k;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  nonint_violation_monitor #(.PI_W(5), .CNT_W(16), .BOUND(4), .TRACE_DEPTH(8)) u_b4 (
    .clock(clock), .reset(reset), .start(start), .step_en(step_en),
    .pi_vec(pi_vec), .po_viol(po_viol), .busy(busy4), .report_valid(rv4),
    .report_ready(report_ready), .status(st4), .fail_cycle(fc4),
    .steps_done(sd4), .trace_rd_idx(trace_rd_idx), .trace_rd_data(td4));

  nonint_violation_monitor #(.PI_W(5), .CNT_W(16), .BOUND(1000), .TRACE_DEPTH(8)) u_b1k (
    .clock(clock), .reset(reset), .start(start), .step_en(step_en),
    .pi_vec(pi_vec), .po_viol(po_viol), .busy(busy1k), .report_valid(rv1k),
    .report_ready(report_ready), .status(st1k), .fail_cycle(fc1k),
    .steps_done(sd1k), .trace_rd_idx(trace_rd_idx), .trace_rd_data(td1k));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic do_step(input logic [4:0] p, input logic v);
    @(negedge clock); step_en = 1'b1; pi_vec = p; po_viol = v;
    @(negedge clock); step_en = 1'b0; po_viol = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx);
    trace_rd_idx = idx;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
  endtask

  initial begin
    // ---------------- reset state
    #2;
    chk("rst_status", st4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_rv", rv4, 0);
    chk("rst_fc", fc4, 0);
    chk("rst_sd", sd4, 0);
    rd(0); chk("rst_trace", td4, 0);
    @(negedge clock); reset = 1'b0;

    // ---------------- clean pass (BOUND=4)
    do_start();
    chk("run_status", st4, 1);
    chk("run_busy", busy4, 1);
    do_step(5'd1, 0); do_step(5'd2, 0); do_step(5'd3, 0);
    chk("pre_pass_status", st4, 1);
    do_step(5'd4, 0);
    chk("pass_status", st4, 2);
    chk("pass_rv", rv4, 1);
    chk("pass_busy", busy4, 0);
    chk("pass_sd", sd4, 4);
    chk("pass_fc", fc4, 0);
    rd(0); chk("pass_tr0", td4, 4);
    rd(3); chk("pass_tr3", td4, 1);
    chk("b1k_still_run", st1k, 1);
    chk("b1k_sd4", sd1k, 4);
    // ready pulse -> IDLE, results retained
    @(negedge clock); report_ready = 1'b1;
    @(negedge clock); report_ready = 1'b0;
    chk("pass_ack_status", st4, 0);
    chk("pass_ack_rv", rv4, 0);
    chk("idle_keep_sd", sd4, 4);
    rd(0); chk("idle_keep_tr0", td4, 4);

    // ---------------- early fail with gaps, hold, ignored inputs
    do_reset();
    do_start();
    do_step(5'h01, 0);
    @(negedge clock); @(negedge clock);  // step_en gap
    chk("gap_sd", sd1k, 1);
    do_step(5'h02, 0);
    do_step(5'h1A, 1);
    chk("ef_status", st1k, 3);
    chk("ef_fc", fc1k, 2);
    chk("ef_sd", sd1k, 3);
    chk("ef_rv", rv1k, 1);
    rd(0); chk("ef_tr0", td1k, 5'h1A);
    rd(1); chk("ef_tr1", td1k, 5'h02);
    do_step(5'h1F, 1);  // ignored in FAIL
    chk("ef_ign_sd", sd1k, 3);
    chk("ef_ign_fc", fc1k, 2);
    rd(0); chk("ef_ign_tr0", td1k, 5'h1A);
    do_start();         // ignored in FAIL
    chk("ef_start_ign", st1k, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_rv", rv1k, 1);
      chk("hold_status", st1k, 3);
      chk("hold_fc", fc1k, 2);
    end
    @(negedge clock); report_ready = 1'b1;
    @(negedge clock); report_ready = 1'b0;
    chk("ef_ack_status", st1k, 0);
    chk("ef_ack_rv", rv1k, 0);
    chk("ef_ack_fc", fc1k, 2);

    // ---------------- violation on last bounded step beats PASS
    do_reset();
    do_start();
    do_step(5'd1, 0); do_step(5'd2, 0); do_step(5'd3, 0);
    do_step(5'd9, 1);
    chk("prio_status", st4, 3);
    chk("prio_fc", fc4, 3);
    chk("prio_sd", sd4, 4);

    // ---------------- trace wrap (BOUND=1000)
    do_reset();
    do_start();
    for (int i = 1; i <= 11; i++) do_step(5'(i), 0);
    do_step(5'd12, 1);
    chk("wrap_status", st1k, 3);
    chk("wrap_fc", fc1k, 11);
    chk("wrap_sd", sd1k, 12);
    rd(0); chk("wrap_tr0", td1k, 12);
    rd(7); chk("wrap_tr7", td1k, 5);
    rd(0); chk("b4_frozen_tr0", td4, 4);
    chk("b4_pass", st4, 2);

    // ---------------- async reset mid-RUN
    do_reset();
    do_start();
    do_step(5'd3, 0); do_step(5'd6, 0); do_step(5'd9, 0);
    @(negedge clock); #2; reset = 1'b1; #1;
    chk("arst_status", st1k, 0);
    chk("arst_busy", busy1k, 0);
    chk("arst_sd", sd1k, 0);
    rd(0); chk("arst_tr0", td1k, 0);
    @(negedge clock); reset = 1'b0;
    do_start();
    do_step(5'd7, 0);
    chk("rerun_sd", sd1k, 1);
    rd(0); chk("rerun_tr0", td1k, 7);
    rd(1); chk("rerun_tr1", td1k, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nonint_violation_monitor.md
Name: nonint_violation_monitor

Overview:
- Downstream consumer of the noninterference miter's single violation output (po0).
- Runs a bounded check: counts design steps from start, stops at the first asserted violation or at BOUND clean steps.
- Retains a ring-buffer trace of the last TRACE_DEPTH input vectors applied to the miter, for counterexample readout.
- Reports PASS/FAIL plus the failing step index through a valid/ready handshake.

Parameters:
- PI_W, 5, width of the miter primary-input vector being traced.
- CNT_W, 16, width of the step counter and fail_cycle.
- BOUND, 1000, number of clean steps required for PASS. Legal range is 1 to 2^CNT_W-1.
- TRACE_DEPTH, 8, trace entries. Must be a power of two, at least 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a check; honoured only in IDLE.
- step_en  in  1  the miter advanced this cycle; pi_vec and po_viol are valid.
- pi_vec  in  PI_W  input vector applied to the miter this step.
- po_viol  in  1  miter violation output (po0); sampled only when step_en=1.
- busy  out  1  high in RUN.
- report_valid  out  1  result available (PASS or FAIL state).
- report_ready  in  1  consumer accepts the result.
- status  out  2  current state encoding.
- fail_cycle  out  CNT_W  0-based index of the violating step; 0 unless FAIL.
- steps_done  out  CNT_W  steps counted in the current or last run.
- trace_rd_idx  in  log2(TRACE_DEPTH)  0 = most recent step, 1 = the step before, and so on.
- trace_rd_data  out  PI_W  combinational read of the selected trace entry.

Behaviour:
- Reset (async assert, synchronous deassert by system): state IDLE.
  - busy=0, report_valid=0, status=0, fail_cycle=0, steps_done=0.
  - All trace entries and the write pointer cleared; trace_rd_data=0.
- State encoding: IDLE=0, RUN=1, PASS=2, FAIL=3.
- IDLE + start=1: next cycle enters RUN. Same edge clears steps_done, fail_cycle, trace entries and write pointer. start in any other state is ignored.
- RUN, step_en=0: no state change.
- RUN, step_en=1:
  - Write pi_vec at the write pointer; the pointer wraps modulo TRACE_DEPTH.
  - steps_done increments by 1.
  - If po_viol=1: enter FAIL; fail_cycle <= the pre-increment steps_done.
  - Else if pre-increment steps_done == BOUND-1: enter PASS.
  - A violation on the final bounded step takes priority: FAIL, not PASS.
- PASS/FAIL: report_valid=1 and outputs held stable.
  - report_valid && report_ready: next cycle to IDLE. Results and trace are retained until the next start.
  - report_valid never drops without ready.
  - step_en and po_viol are ignored in these states.
- Trace read:
  - Entry k = pi_vec of the step k places before the most recent write.
  - Entries never written since start read 0.
  - Writes wrap, so only the last TRACE_DEPTH steps are kept.
  - Trace writes only in RUN; it is frozen otherwise.
- steps_done saturates at 2^CNT_W-1. Unreachable given the BOUND range, but required.
- Reset mid-RUN or mid-report: immediate return to the reset state; partial results discarded.
- Latency: status and report_valid update on the clock edge after the deciding step; no combinational path from po_viol to any output.

Decomposition:
- Shared package nonint_pkg:
  - 2-bit state/status type and its constants (ST_IDLE, ST_RUN, ST_PASS, ST_FAIL).
  - Default PI_W.
- One sub-module, nonint_trace_buf:
  - Parameterised ring buffer with write-enable and clear.
  - Write pointer; relative-index combinational read port (rd_idx back from latest).
  - Clear-all-on-start and async reset.
- FSM and counters live in the top.

Test Plan:
- Clean pass: BOUND=4, start, 4 steps with po_viol=0, pi_vec 1,2,3,4 -> status=2, report_valid=1, steps_done=4, fail_cycle=0; trace idx0=4, idx3=1.
- Early fail: BOUND=1000, violation on the 3rd step (pi_vec=5'h1A) -> status=3, fail_cycle=2, steps_done=3, trace idx0=5'h1A; later step_en pulses ignored.
- Final-step priority: BOUND=4, po_viol=1 on step index 3 -> FAIL, fail_cycle=3, not PASS.
- Handshake and gaps:
  - step_en gaps in RUN do not count.
  - report_ready held low 5 cycles -> report_valid and outputs stable.
  - Ready pulse -> IDLE next cycle; start while in FAIL is ignored.
- Trace wrap: TRACE_DEPTH=8, 11 clean steps pi_vec=1..11, then fail on step 12 with pi_vec=12 -> idx0=12, idx7=5.
- Reset mid-RUN after 3 steps -> all outputs 0 immediately (asynchronous). A new start then runs from steps_done=0 with cleared trace (idx1 reads 0 after one step).
